// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button conditioning, IDLE/RUN/PAUSED/LAP sequencing,
// tenths prescaler, seconds/tenths counters and lap display mux.
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   btn_start_stop  raw push button, active-high, asynchronous
//   btn_lap         raw push button, active-high, asynchronous
//   btn_clear       raw push button, active-high, asynchronous
//   tick            one-cycle pulse per counted tenth
//   overflow        one-cycle pulse on SEC_MAX.9 -> 0.0 wrap
//   running         high in RUN or LAP
//   lap_active      high in LAP
//   state           IDLE=0, RUN=1, PAUSED=2, LAP=3
//   seconds         live seconds, 0..SEC_MAX
//   m_seconds       live tenths, 0..9
//   disp_seconds    displayed seconds (lap snapshot while in LAP)
//   disp_m_seconds  displayed tenths (lap snapshot while in LAP)

// Button conditioner: 2-FF synchronizer, stability timer, rising-edge command.
module stopwatch_btn #(
   parameter int DB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic cmd
);
   localparam int CW = $clog2(DB_CYCLES + 1);

   logic          sync_1;
   logic          sync_2;
   logic          level;
   logic [CW-1:0] db_cnt;

   // db_cnt is a down-counter reloaded whenever the synchronized level agrees
   // with the accepted one; reaching zero while they disagree means the new
   // level has held for DB_CYCLES consecutive cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         level  <= 1'b0;
         db_cnt <= CW'(DB_CYCLES - 1);
         cmd    <= 1'b0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
         cmd    <= 1'b0;
         if (sync_2 == level) begin
            db_cnt <= CW'(DB_CYCLES - 1);
         end else if (db_cnt == '0) begin
            level  <= sync_2;
            cmd    <= sync_2;
            db_cnt <= CW'(DB_CYCLES - 1);
         end else begin
            db_cnt <= db_cnt - 1'b1;
         end
      end
   end
endmodule

// state  | meaning
// IDLE   | cleared, not counting
// RUN    | counting, display shows live count
// PAUSED | count and prescaler frozen, clear allowed
// LAP    | counting, display shows frozen snapshot
module stopwatch_ctrl #(
   parameter int CLK_HZ    = 50000000,
   parameter int TICK_HZ   = 10,
   parameter int SEC_MAX   = 999,
   parameter int DB_CYCLES = 500000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_start_stop,
   input  logic        btn_lap,
   input  logic        btn_clear,
   output logic        tick,
   output logic        overflow,
   output logic        running,
   output logic        lap_active,
   output logic [1:0]  state,
   output logic [31:0] seconds,
   output logic [31:0] m_seconds,
   output logic [31:0] disp_seconds,
   output logic [31:0] disp_m_seconds
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      LAP    = 2'd3
   } state_t;

   state_t        st;
   logic [PW-1:0] presc;
   logic [31:0]   snap_seconds;
   logic [31:0]   snap_m_seconds;
   logic          cmd_ss;
   logic          cmd_lap;
   logic          cmd_clr;
   logic          do_ss;
   logic          do_lap;
   logic          do_clr;
   logic          counting;

   stopwatch_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_ss (
      .clk(clk), .rst_n(rst_n), .raw(btn_start_stop), .cmd(cmd_ss)
   );
   stopwatch_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_lap (
      .clk(clk), .rst_n(rst_n), .raw(btn_lap), .cmd(cmd_lap)
   );
   stopwatch_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_clr (
      .clk(clk), .rst_n(rst_n), .raw(btn_clear), .cmd(cmd_clr)
   );

   // Coincident commands: only the highest-priority one survives, even when
   // the current state would ignore it.
   assign do_clr = cmd_clr;
   assign do_ss  = cmd_ss & ~cmd_clr;
   assign do_lap = cmd_lap & ~cmd_ss & ~cmd_clr;

   assign counting = (st == RUN) || (st == LAP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st             <= IDLE;
         presc          <= '0;
         seconds        <= '0;
         m_seconds      <= '0;
         snap_seconds   <= '0;
         snap_m_seconds <= '0;
         tick           <= 1'b0;
         overflow       <= 1'b0;
      end else begin
         tick     <= 1'b0;
         overflow <= 1'b0;

         // A tick in the same cycle as a command is always counted; the
         // state change below only affects later cycles.
         if (counting) begin
            if (presc == PW'(DIV - 1)) begin
               presc <= '0;
               tick  <= 1'b1;
               if (m_seconds == 32'd9) begin
                  m_seconds <= '0;
                  if (seconds == 32'(SEC_MAX)) begin
                     seconds  <= '0;
                     overflow <= 1'b1;
                  end else begin
                     seconds <= seconds + 32'd1;
                  end
               end else begin
                  m_seconds <= m_seconds + 32'd1;
               end
            end else begin
               presc <= presc + 1'b1;
            end
         end

         case (st)
            IDLE: begin
               if (do_ss) st <= RUN;
            end
            RUN: begin
               if (do_ss) begin
                  st <= PAUSED;
               end else if (do_lap) begin
                  st             <= LAP;
                  snap_seconds   <= seconds;
                  snap_m_seconds <= m_seconds;
               end
            end
            LAP: begin
               if (do_ss) st <= PAUSED;
               else if (do_lap) st <= RUN;
            end
            PAUSED: begin
               if (do_ss) begin
                  st <= RUN;
               end else if (do_clr) begin
                  st        <= IDLE;
                  presc     <= '0;
                  seconds   <= '0;
                  m_seconds <= '0;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

   assign state          = st;
   assign running        = counting;
   assign lap_active     = (st == LAP);
   assign disp_seconds   = lap_active ? snap_seconds   : seconds;
   assign disp_m_seconds = lap_active ? snap_m_seconds : m_seconds;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: fixed vector table with hand-derived expectations,
// async reset sequence, and random button traffic against a reference model.
module tb_stopwatch_ctrl;
   localparam int CLK_HZ    = 100;
   localparam int TICK_HZ   = 10;
   localparam int SEC_MAX   = 2;
   localparam int DB_CYCLES = 4;
   localparam int DIV       = CLK_HZ / TICK_HZ;
   localparam int PER       = 10 * (SEC_MAX + 1);
   localparam int S_IDLE    = 0;
   localparam int S_RUN     = 1;
   localparam int S_PAUSED  = 2;
   localparam int S_LAP     = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        btn_start_stop = 1'b0;
   logic        btn_lap = 1'b0;
   logic        btn_clear = 1'b0;
   logic        tick;
   logic        overflow;
   logic        running;
   logic        lap_active;
   logic [1:0]  state;
   logic [31:0] seconds;
   logic [31:0] m_seconds;
   logic [31:0] disp_seconds;
   logic [31:0] disp_m_seconds;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: m_rc counts running cycles since the last clear; the
   // displayed time is just that count divided down and wrapped.
   int          m_state;
   int          m_rc;
   int          m_snap;
   bit          m_tick;
   bit          m_ovf;
   logic [2:0]  m_d1;
   logic [2:0]  m_d2;
   logic [2:0]  m_acc;
   logic [2:0]  m_cmd;
   logic [31:0] m_hist [3];

   typedef struct {
      logic [2:0] btn;
      int         press;
      int         total;
      int         st;
      int         sec;
      int         ms;
      int         dsec;
      int         dms;
      int         tk;
      int         ov;
   } vec_t;

   stopwatch_ctrl #(
      .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SEC_MAX(SEC_MAX), .DB_CYCLES(DB_CYCLES)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn_start_stop(btn_start_stop),
      .btn_lap(btn_lap),
      .btn_clear(btn_clear),
      .tick(tick),
      .overflow(overflow),
      .running(running),
      .lap_active(lap_active),
      .state(state),
      .seconds(seconds),
      .m_seconds(m_seconds),
      .disp_seconds(disp_seconds),
      .disp_m_seconds(disp_m_seconds)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = S_IDLE;
      m_rc    = 0;
      m_snap  = 0;
      m_tick  = 1'b0;
      m_ovf   = 1'b0;
      m_d1    = '0;
      m_d2    = '0;
      m_acc   = '0;
      m_cmd   = '0;
      for (int b = 0; b < 3; b++) m_hist[b] = '0;
   endtask

   // raw bit0 = start_stop, bit1 = lap, bit2 = clear
   task automatic model_edge(input logic [2:0] raw);
      int          rc_old;
      logic [2:0]  nc;
      logic [31:0] mask;
      rc_old = m_rc;
      m_tick = 1'b0;
      m_ovf  = 1'b0;
      if (m_state == S_RUN || m_state == S_LAP) begin
         m_rc++;
         if (m_rc % DIV == 0) begin
            m_tick = 1'b1;
            m_ovf  = ((m_rc / DIV) % PER == 0);
         end
      end
      if (m_cmd[2]) begin
         if (m_state == S_PAUSED) begin
            m_state = S_IDLE;
            m_rc    = 0;
         end
      end else if (m_cmd[0]) begin
         if (m_state == S_RUN || m_state == S_LAP) m_state = S_PAUSED;
         else m_state = S_RUN;
      end else if (m_cmd[1]) begin
         if (m_state == S_RUN) begin
            m_state = S_LAP;
            m_snap  = (rc_old / DIV) % PER;
         end else if (m_state == S_LAP) begin
            m_state = S_RUN;
         end
      end
      // A button level is accepted once the last DB_CYCLES synchronized
      // samples all disagree with the currently accepted level.
      mask = (32'd1 << DB_CYCLES) - 32'd1;
      nc   = '0;
      for (int b = 0; b < 3; b++) begin
         m_hist[b] = {m_hist[b][30:0], m_d2[b]};
         if ((m_hist[b] & mask) == (m_acc[b] ? 32'd0 : mask)) begin
            m_acc[b] = ~m_acc[b];
            nc[b]    = m_acc[b];
         end
      end
      m_d2  = m_d1;
      m_d1  = raw;
      m_cmd = nc;
   endtask

   task automatic check_all(input string tag);
      int t;
      int d;
      t = (m_rc / DIV) % PER;
      d = (m_state == S_LAP) ? m_snap : t;
      chk({tag, ".state"}, 32'(state), 32'(m_state));
      chk({tag, ".tick"}, 32'(tick), 32'(m_tick));
      chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
      chk({tag, ".running"}, 32'(running), 32'(m_state == S_RUN || m_state == S_LAP));
      chk({tag, ".lap_active"}, 32'(lap_active), 32'(m_state == S_LAP));
      chk({tag, ".seconds"}, seconds, 32'(t / 10));
      chk({tag, ".m_seconds"}, m_seconds, 32'(t % 10));
      chk({tag, ".disp_seconds"}, disp_seconds, 32'(d / 10));
      chk({tag, ".disp_m_seconds"}, disp_m_seconds, 32'(d % 10));
   endtask

   task automatic step(input logic [2:0] b);
      btn_start_stop = b[0];
      btn_lap        = b[1];
      btn_clear      = b[2];
      @(posedge clk);
      model_edge(b);
      #1;
      check_all("cyc");
   endtask

   initial begin
      vec_t tbl [26];
      // btn, press, total, state, sec, ms, disp_sec, disp_ms, tick, overflow
      tbl[0]  = '{3'b001,  2,  12, S_IDLE,   0, 0, 0, 0, 0, 0};
      tbl[1]  = '{3'b001, 10, 107, S_RUN,    1, 0, 1, 0, 1, 0};
      tbl[2]  = '{3'b000,  0,  30, S_RUN,    1, 3, 1, 3, 1, 0};
      tbl[3]  = '{3'b010,  4,  50, S_LAP,    1, 8, 1, 3, 1, 0};
      tbl[4]  = '{3'b010,  4,   7, S_RUN,    1, 8, 1, 8, 0, 0};
      tbl[5]  = '{3'b000,  0,   2, S_RUN,    1, 8, 1, 8, 0, 0};
      tbl[6]  = '{3'b001,  4,   7, S_PAUSED, 1, 9, 1, 9, 0, 0};
      tbl[7]  = '{3'b000,  0,  50, S_PAUSED, 1, 9, 1, 9, 0, 0};
      tbl[8]  = '{3'b001,  4,  10, S_RUN,    1, 9, 1, 9, 0, 0};
      tbl[9]  = '{3'b000,  0,   1, S_RUN,    2, 0, 2, 0, 1, 0};
      tbl[10] = '{3'b000,  0,  99, S_RUN,    2, 9, 2, 9, 0, 0};
      tbl[11] = '{3'b000,  0,   1, S_RUN,    0, 0, 0, 0, 1, 1};
      tbl[12] = '{3'b000,  0,   1, S_RUN,    0, 0, 0, 0, 0, 0};
      tbl[13] = '{3'b100,  4,   7, S_RUN,    0, 0, 0, 0, 0, 0};
      tbl[14] = '{3'b000,  0,   2, S_RUN,    0, 1, 0, 1, 1, 0};
      tbl[15] = '{3'b001,  4,   7, S_PAUSED, 0, 1, 0, 1, 0, 0};
      tbl[16] = '{3'b000,  0,   2, S_PAUSED, 0, 1, 0, 1, 0, 0};
      tbl[17] = '{3'b100,  4,   7, S_IDLE,   0, 0, 0, 0, 0, 0};
      tbl[18] = '{3'b000,  0,   2, S_IDLE,   0, 0, 0, 0, 0, 0};
      tbl[19] = '{3'b001,  4,   7, S_RUN,    0, 0, 0, 0, 0, 0};
      tbl[20] = '{3'b000,  0,  10, S_RUN,    0, 1, 0, 1, 1, 0};
      tbl[21] = '{3'b001,  4,   7, S_PAUSED, 0, 1, 0, 1, 0, 0};
      tbl[22] = '{3'b000,  0,   2, S_PAUSED, 0, 1, 0, 1, 0, 0};
      tbl[23] = '{3'b101,  4,   7, S_IDLE,   0, 0, 0, 0, 0, 0};
      tbl[24] = '{3'b000,  0,   2, S_IDLE,   0, 0, 0, 0, 0, 0};
      tbl[25] = '{3'b010,  4,   7, S_IDLE,   0, 0, 0, 0, 0, 0};

      model_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 26; i++) begin
         for (int k = 0; k < tbl[i].total; k++)
            step((k < tbl[i].press) ? tbl[i].btn : 3'b000);
         chk($sformatf("tbl%0d.state", i), 32'(state), 32'(tbl[i].st));
         chk($sformatf("tbl%0d.seconds", i), seconds, 32'(tbl[i].sec));
         chk($sformatf("tbl%0d.m_seconds", i), m_seconds, 32'(tbl[i].ms));
         chk($sformatf("tbl%0d.disp_seconds", i), disp_seconds, 32'(tbl[i].dsec));
         chk($sformatf("tbl%0d.disp_m_seconds", i), disp_m_seconds, 32'(tbl[i].dms));
         chk($sformatf("tbl%0d.tick", i), 32'(tick), 32'(tbl[i].tk));
         chk($sformatf("tbl%0d.overflow", i), 32'(overflow), 32'(tbl[i].ov));
      end

      // Start, run to 0.3, then pull reset between clock edges.
      repeat (4) step(3'b001);
      repeat (40) step(3'b000);
      chk("pre_reset.state", 32'(state), 32'(S_RUN));
      chk("pre_reset.m_seconds", m_seconds, 32'd3);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_reset.state", 32'(state), 32'(S_IDLE));
      chk("async_reset.seconds", seconds, 32'd0);
      chk("async_reset.m_seconds", m_seconds, 32'd0);
      chk("async_reset.running", 32'(running), 32'd0);
      check_all("async_reset");
      repeat (2) @(negedge clk);
      check_all("held_reset");
      rst_n = 1'b1;

      for (int n = 0; n < 150; n++) begin
         logic [2:0] b;
         int         h;
         int         g;
         b = 3'($urandom_range(1, 7));
         h = $urandom_range(1, 10);
         g = $urandom_range(1, 80);
         repeat (h) step(b);
         repeat (g) step(3'b000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
